// File: rtl/i2c_req_arbiter_if.sv
// Request/response and I2C-master command signals shared by the arbiter and its clients.
// slave is the arbiter's view; master is the clients' and I2C master's view.
interface i2c_req_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_rw;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_nack;
    logic              rsp_timeout;
    logic [7:0]        rsp_rdata;
    logic              m_start;
    logic [6:0]        m_addr;
    logic              m_rw;
    logic [7:0]        m_wdata;
    logic              m_abort;
    logic              m_done;
    logic              m_nack;
    logic [7:0]        m_rdata;

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata, m_done, m_nack, m_rdata,
        output req_ready, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata,
               m_start, m_addr, m_rw, m_wdata, m_abort
    );

    modport master (
        output req_valid, req_addr, req_rw, req_wdata, m_done, m_nack, m_rdata,
        input  req_ready, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata,
               m_start, m_addr, m_rw, m_wdata, m_abort
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin scheduler sharing one I2C byte-transaction master among NREQ requesters,
// with a completion timeout that abandons a stuck transfer.
module i2c_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    i2c_req_arbiter_if.slave bus,
    output logic            busy
);
    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic          m_rw_q, m_rw_d;
    logic [7:0]    m_wdata_q, m_wdata_d;
    logic          rsp_nack_q, rsp_nack_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;

    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic          found;

    // First set request at or after last_grant+1, wrapping modulo NREQ
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = GW'((32'(last_grant_q) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        timer_d       = timer_q;
        m_addr_d      = m_addr_q;
        m_rw_d        = m_rw_q;
        m_wdata_d     = m_wdata_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d   = winner;
                    m_addr_d  = bus.req_addr[32'(winner) * 7 +: 7];
                    m_rw_d    = bus.req_rw[winner];
                    m_wdata_d = bus.req_wdata[32'(winner) * 8 +: 8];
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: state_d = S_ISSUE;
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final timer cycle takes priority over the timeout
                if (bus.m_done) begin
                    rsp_nack_d    = bus.m_nack;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = bus.m_rdata;
                    state_d       = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_nack_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GW'(NREQ - 1);
            grant_q       <= '0;
            timer_q       <= '0;
            m_addr_q      <= '0;
            m_rw_q        <= 1'b0;
            m_wdata_q     <= '0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            timer_q       <= timer_d;
            m_addr_q      <= m_addr_d;
            m_rw_q        <= m_rw_d;
            m_wdata_q     <= m_wdata_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == S_GRANT) bus.req_ready[grant_q] = 1'b1;
        if (state_q == S_RESP)  bus.rsp_valid[grant_q] = 1'b1;
    end

    assign bus.m_start     = (state_q == S_ISSUE);
    assign bus.m_abort     = (state_q == S_RESP) && rsp_timeout_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_rw        = m_rw_q;
    assign bus.m_wdata     = m_wdata_q;
    assign bus.rsp_nack    = rsp_nack_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign busy            = (state_q != S_IDLE);
endmodule
